// File: rtl/mbist_mem_responder.sv
// Memory-side responder for the march-test BIST controller: up/down address counter,
// DEPTH x 1-bit array, compare logic, saturating mismatch counter and stuck-at injection.
module mbist_mem_responder #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 2 ** ADDR_W,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset,
  input  logic              preset,
  input  logic              en,
  input  logic              up_down,
  input  logic              read,
  input  logic              write,
  input  logic              data,
  input  logic              fault_en,
  input  logic [ADDR_W-1:0] fault_addr,
  input  logic              fault_val,
  output logic              carry,
  output logic              is_equal,
  output logic [ADDR_W-1:0] addr,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              proto_err
);

  localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(DEPTH - 1);
  localparam logic [ERR_W-1:0]  ErrMax  = {ERR_W{1'b1}};

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]  mem_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic              proto_err_q;
  logic              rd_bit;
  logic              rd_op;
  logic              wr_op;
  logic              mismatch;

  // Simultaneous read and write is a protocol violation: neither operation takes effect.
  assign rd_op = read & ~write;
  assign wr_op = write & ~read;

  // Injection only masks the read path; stored contents stay intact.
  assign rd_bit   = (fault_en && (addr_q == fault_addr)) ? fault_val : mem_q[addr_q];
  assign mismatch = rd_op & (rd_bit != data);

  always_comb begin
    addr_d = addr_q;
    if (reset) begin
      addr_d = '0;
    end else if (preset) begin
      addr_d = AddrMax;
    end else if (en) begin
      addr_d = up_down ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      mem_q       <= '0;
      err_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      if (wr_op) begin
        mem_q[addr_q] <= data;
      end
      if (mismatch && (err_cnt_q != ErrMax)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
      if (read && write) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // carry depends only on addr and direction, never on en, to avoid a loop via the controller.
  assign carry     = up_down ? (addr_q == AddrMax) : (addr_q == '0);
  assign is_equal  = ~mismatch;
  assign addr      = addr_q;
  assign err_cnt   = err_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: doc/mbist_mem_responder.md
# mbist_mem_responder

Memory-side responder for the march-test BIST controller. It owns the up/down address counter and a DEPTH x 1-bit memory array. It answers the controller's `reset`/`preset`/`en`/`up_down` counter commands with `carry`, and its `read`/`write`/`data` memory commands with `is_equal`. It sits between the BIST controller and the array under test, with a stuck-at fault injector so the controller's fail path can be exercised.

## Interface
Parameters:
- ADDR_W, 4, address width
- DEPTH, 2**ADDR_W, number of 1-bit cells; must equal 2**ADDR_W
- ERR_W, 8, width of the saturating mismatch counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- reset  in  1  synchronous counter clear to 0
- preset  in  1  synchronous counter load to DEPTH-1
- en  in  1  counter step enable
- up_down  in  1  1 = count up, 0 = count down
- read  in  1  read/compare strobe
- write  in  1  write strobe
- data  in  1  write data, and expected data on reads
- fault_en  in  1  enable stuck-at injection
- fault_addr  in  ADDR_W  cell the injected fault applies to
- fault_val  in  1  stuck-at value
- carry  out  1  terminal count reached for the current direction
- is_equal  out  1  read data matches `data`
- addr  out  ADDR_W  current address (registered)
- err_cnt  out  ERR_W  saturating count of mismatching read cycles
- proto_err  out  1  sticky: read and write were asserted together

## Operation
- Reset values (rst=1):
  - addr=0, err_cnt=0, proto_err=0.
  - All array cells = 0.
  - is_equal=1 and carry=(up_down==0), both combinational from reset state.
- Counter priority per rising edge: reset > preset > en > hold.
  - reset: addr<=0.
  - preset: addr<=DEPTH-1.
  - en with up_down=1: addr<=addr+1, wrapping DEPTH-1 -> 0.
  - en with up_down=0: addr<=addr-1, wrapping 0 -> DEPTH-1.
  - reset and preset together: reset wins, addr<=0.
- carry is combinational from the registered addr and the current up_down only:
  - up_down=1: carry = (addr==DEPTH-1).
  - up_down=0: carry = (addr==0).
  - carry has no dependence on en, which avoids a loop through the controller.
- Write: on the edge with write=1 and read=0, mem[addr]<=data. Uses the pre-increment addr of that same edge. Independent of en.
- Read value rd_bit:
  - fault_val when fault_en=1 and addr==fault_addr.
  - mem[addr] otherwise.
  - The array contents themselves are never altered by injection.
- is_equal, combinational:
  - read=1, write=0: is_equal = (rd_bit==data).
  - Otherwise: is_equal = 1.
- err_cnt: increments on each edge where read=1, write=0 and rd_bit!=data. Saturates at 2**ERR_W-1. Cleared only by rst; unaffected by the reset input.
- Read and write together:
  - Neither operation happens: no array update, is_equal=1, no err_cnt change.
  - proto_err<=1 and stays set until rst.
- The reset and preset inputs never touch array contents.

## Timing
- addr changes one clk after the commanding edge. carry follows addr/up_down with zero added cycles.
- Write at edge N stores to the addr valid before edge N. A read of that cell is first valid in the cycle after edge N.
- is_equal is valid in the same cycle as read, addr and data, in time for the controller to sample it at the next edge.
- Counting full sweep, from addr=0 with en=1 and up_down=1:
  - carry=1 during cycle DEPTH-1 (addr=DEPTH-1).
  - If en stays high, addr wraps to 0 at the next edge.
- rst mid-sweep: immediate asynchronous return to reset values. Any in-flight write is discarded.

## Test plan
- Reset check:
  - Stimulus: rst pulse with up_down=1.
  - Response: addr=0, carry=0, is_equal=1, err_cnt=0, proto_err=0. Toggling up_down to 0 -> carry=1.
- March w0-up / r0-down (DEPTH=16):
  - Stimulus: reset, then 16 cycles of write=1, data=0, en=1, up_down=1. carry=1 exactly when addr=15.
  - Stimulus continues: preset, then read=1, data=0, en=1, up_down=0.
  - Response: is_equal=1 on every cycle, carry=1 at addr=0, err_cnt=0.
- Fault injection:
  - Stimulus: cells written to 0; fault_en=1, fault_addr=5, fault_val=1; read sweep with data=0.
  - Response: is_equal=0 only when addr=5, err_cnt=1 after the sweep.
  - Stimulus: fault_en=0, re-read.
  - Response: is_equal=1 everywhere, showing the array is unmodified.
- Counter edges:
  - en at addr=15, up -> addr=0.
  - en at addr=0, down -> addr=15.
  - reset and preset in the same cycle -> addr=0.
  - preset with en=1 -> addr=15.
- Protocol error:
  - Stimulus: read=1 and write=1 with data=1 at addr=3, previously written 0.
  - Response: proto_err=1 (sticky), is_equal=1, a later read of addr 3 with data=0 gives is_equal=1, err_cnt unchanged.
- Saturation and mid-run reset:
  - Stimulus: a forced mismatch for 300 read cycles with ERR_W=8.
  - Response: err_cnt=255.
  - Stimulus: assert rst mid-sweep.
  - Response: addr=0, err_cnt=0, all cells read back 0.
